pcpi_issuer: RTL and testbench

Core-side PCPI initiator: accepts one instruction plus operands from the pipeline, drives it onto the PCPI bus toward coprocessor extensions (ALU/shift/load-store extension), waits for `pcpi_ready` or a timeout, and returns a register-writeback response. It is the requester end of the PCPI handshake whose responder is the extension block. It holds one instruction in flight at a time and handles backpressure on both upstream and downstream sides.

---
 rtl/pcpi_pkg.sv | 25 ++
 rtl/pcpi_issuer_if.sv | 36 +++
 rtl/pcpi_timeout_ctr.sv | 29 ++
 rtl/pcpi_issuer.sv | 119 +++++++++++
 tb/tb_pcpi_issuer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pcpi_pkg.sv
// Shared types and constants for the core-side PCPI issuer.
package pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } pcpi_iss_state_t;

  localparam int unsigned PCPI_TIMEOUT_DEFAULT = 16;
  localparam int unsigned RD_LSB = 7;
  localparam int unsigned RD_MSB = 11;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rdidx;
    logic [31:0] rd;
    logic        illegal;
  } pcpi_rsp_t;

  function automatic logic [4:0] insn_rdidx(input logic [31:0] insn);
    return insn[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/pcpi_issuer_if.sv
// Upstream request, PCPI bus and writeback response signals of the issuer.
interface pcpi_issuer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_insn_i;
  logic [31:0] req_rs1_i;
  logic [31:0] req_rs2_i;
  logic        pcpi_valid_o;
  logic [31:0] pcpi_insn_o;
  logic [31:0] pcpi_rs1_o;
  logic [31:0] pcpi_rs2_o;
  logic        pcpi_wr_i;
  logic [31:0] pcpi_rd_i;
  logic        pcpi_wait_i;
  logic        pcpi_ready_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_wr_o;
  logic [4:0]  rsp_rdidx_o;
  logic [31:0] rsp_rd_o;
  logic        rsp_illegal_o;

  modport master (
    input  req_valid_i, req_insn_i, req_rs1_i, req_rs2_i,
    input  pcpi_wr_i, pcpi_rd_i, pcpi_wait_i, pcpi_ready_i, rsp_ready_i,
    output req_ready_o, pcpi_valid_o, pcpi_insn_o, pcpi_rs1_o, pcpi_rs2_o,
    output rsp_valid_o, rsp_wr_o, rsp_rdidx_o, rsp_rd_o, rsp_illegal_o
  );

  modport slave (
    output req_valid_i, req_insn_i, req_rs1_i, req_rs2_i,
    output pcpi_wr_i, pcpi_rd_i, pcpi_wait_i, pcpi_ready_i, rsp_ready_i,
    input  req_ready_o, pcpi_valid_o, pcpi_insn_o, pcpi_rs1_o, pcpi_rs2_o,
    input  rsp_valid_o, rsp_wr_o, rsp_rdidx_o, rsp_rd_o, rsp_illegal_o
  );
endinterface

// File: rtl/pcpi_timeout_ctr.sv
// Counts consecutive non-wait issue cycles; expired marks the last allowed one.
module pcpi_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] count_r;

  // Counter register: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (inc) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pcpi_issuer.sv
// Core-side PCPI initiator: one instruction in flight, timeout marks it illegal,
// response held until the writeback stage accepts it.
module pcpi_issuer
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PCPI_TIMEOUT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  pcpi_issuer_if.master bus
);

  pcpi_iss_state_t state_r, state_s;
  logic [31:0]     insn_r, rs1_r, rs2_r;
  pcpi_rsp_t       rsp_r, rsp_s;
  logic            load_rsp_s, accept_s, ctr_clr_s, ctr_inc_s, expired_s;
  logic            req_ready_r, pcpi_valid_r, rsp_valid_r;

  pcpi_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr_s),
    .inc     (ctr_inc_s),
    .expired (expired_s)
  );

  // Next-state, timeout control and response capture.
  always_comb begin
    state_s    = state_r;
    rsp_s      = rsp_r;
    load_rsp_s = 1'b0;
    accept_s   = 1'b0;
    ctr_clr_s  = 1'b1;
    ctr_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid_i) begin
          accept_s = 1'b1;
          state_s  = ISSUE;
        end else begin
          state_s  = IDLE;
        end
      end
      ISSUE: begin
        ctr_clr_s = 1'b0;
        if (bus.pcpi_ready_i) begin
          state_s       = RESP;
          load_rsp_s    = 1'b1;
          rsp_s.rdidx   = insn_rdidx(insn_r);
          rsp_s.wr      = bus.pcpi_wr_i && (insn_rdidx(insn_r) != 5'd0);
          rsp_s.rd      = bus.pcpi_wr_i ? bus.pcpi_rd_i : 32'd0;
          rsp_s.illegal = 1'b0;
        end else if (bus.pcpi_wait_i) begin
          ctr_clr_s = 1'b1;
        end else if (expired_s) begin
          state_s       = RESP;
          load_rsp_s    = 1'b1;
          rsp_s.rdidx   = insn_rdidx(insn_r);
          rsp_s.wr      = 1'b0;
          rsp_s.rd      = 32'd0;
          rsp_s.illegal = 1'b1;
        end else begin
          ctr_inc_s = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand latches and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      insn_r       <= 32'd0;
      rs1_r        <= 32'd0;
      rs2_r        <= 32'd0;
      rsp_r        <= '0;
      req_ready_r  <= 1'b1;
      pcpi_valid_r <= 1'b0;
      rsp_valid_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        insn_r <= bus.req_insn_i;
        rs1_r  <= bus.req_rs1_i;
        rs2_r  <= bus.req_rs2_i;
      end
      if (load_rsp_s) begin
        rsp_r <= rsp_s;
      end
      req_ready_r  <= (state_s == IDLE);
      pcpi_valid_r <= (state_s == ISSUE);
      rsp_valid_r  <= (state_s == RESP);
    end
  end

  assign bus.req_ready_o   = req_ready_r;
  assign bus.pcpi_valid_o  = pcpi_valid_r;
  assign bus.pcpi_insn_o   = insn_r;
  assign bus.pcpi_rs1_o    = rs1_r;
  assign bus.pcpi_rs2_o    = rs2_r;
  assign bus.rsp_valid_o   = rsp_valid_r;
  assign bus.rsp_wr_o      = rsp_r.wr;
  assign bus.rsp_rdidx_o   = rsp_r.rdidx;
  assign bus.rsp_rd_o      = rsp_r.rd;
  assign bus.rsp_illegal_o = rsp_r.illegal;

endmodule

// File: tb/tb_pcpi_issuer.sv
// Transaction-level model of pcpi_issuer: each instruction's issue length and
// response are derived from the stub schedule, then checked every cycle.
module tb_pcpi_issuer;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcpi_issuer_if bus();

  pcpi_issuer #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  bit          chk_en = 1'b0;
  bit          chk_pcpi = 1'b0;
  bit          chk_rsp = 1'b0;
  logic        exp_req_ready, exp_pcpi_valid, exp_rsp_valid, exp_wr, exp_ill;
  logic [31:0] exp_insn, exp_rs1, exp_rs2, exp_rd;
  logic [4:0]  exp_idx;

  int          cyc = 0, rise_cyc = 0, last_lat = 0, nrsp = 0;
  logic        prev_pv = 1'b0, prev_rv = 1'b0;
  logic        mon_wr = 1'b0, mon_ill = 1'b0;
  logic [4:0]  mon_idx = 5'd0;
  logic [31:0] mon_rd = 32'd0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_ready", 32'(bus.req_ready_o), 32'(exp_req_ready));
      cmp("pcpi_valid", 32'(bus.pcpi_valid_o), 32'(exp_pcpi_valid));
      cmp("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_rsp_valid));
      if (chk_pcpi) begin
        cmp("pcpi_insn", bus.pcpi_insn_o, exp_insn);
        cmp("pcpi_rs1", bus.pcpi_rs1_o, exp_rs1);
        cmp("pcpi_rs2", bus.pcpi_rs2_o, exp_rs2);
      end
      if (chk_rsp) begin
        cmp("rsp_wr", 32'(bus.rsp_wr_o), 32'(exp_wr));
        cmp("rsp_rdidx", 32'(bus.rsp_rdidx_o), 32'(exp_idx));
        cmp("rsp_rd", bus.rsp_rd_o, exp_rd);
        cmp("rsp_illegal", 32'(bus.rsp_illegal_o), 32'(exp_ill));
      end
    end
  end

  // Monitor: issue-to-response latency and response fields for literal checks.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_pv <= bus.pcpi_valid_o;
    prev_rv <= bus.rsp_valid_o;
    if (bus.pcpi_valid_o && !prev_pv) rise_cyc <= cyc;
    if (bus.rsp_valid_o && !prev_rv) begin
      last_lat <= cyc - rise_cyc;
      nrsp     <= nrsp + 1;
      mon_wr   <= bus.rsp_wr_o;
      mon_idx  <= bus.rsp_rdidx_o;
      mon_rd   <= bus.rsp_rd_o;
      mon_ill  <= bus.rsp_illegal_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_req_ready = 1'b1; exp_pcpi_valid = 1'b0; exp_rsp_valid = 1'b0;
    chk_pcpi = 1'b0; chk_rsp = 1'b0;
  endtask

  task automatic set_reset();
    set_idle();
    chk_pcpi = 1'b1; chk_rsp = 1'b1;
    exp_insn = 32'd0; exp_rs1 = 32'd0; exp_rs2 = 32'd0;
    exp_wr = 1'b0; exp_idx = 5'd0; exp_rd = 32'd0; exp_ill = 1'b0;
  endtask

  task automatic set_issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    exp_req_ready = 1'b0; exp_pcpi_valid = 1'b1; exp_rsp_valid = 1'b0;
    chk_pcpi = 1'b1; chk_rsp = 1'b0;
    exp_insn = insn; exp_rs1 = rs1; exp_rs2 = rs2;
  endtask

  task automatic set_resp(input logic wr, input logic [4:0] idx, input logic [31:0] rd, input logic ill);
    exp_req_ready = 1'b0; exp_pcpi_valid = 1'b0; exp_rsp_valid = 1'b1;
    chk_pcpi = 1'b0; chk_rsp = 1'b1;
    exp_wr = wr; exp_idx = idx; exp_rd = rd; exp_ill = ill;
  endtask

  task automatic drive_stub(input logic w, input logic r, input logic wr, input logic [31:0] rd);
    bus.pcpi_wait_i = w; bus.pcpi_ready_i = r; bus.pcpi_wr_i = wr; bus.pcpi_rd_i = rd;
  endtask

  task automatic junk_inputs();
    drive_stub(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    bus.rsp_ready_i = 1'($urandom);
    bus.req_insn_i = $urandom; bus.req_rs1_i = $urandom; bus.req_rs2_i = $urandom;
  endtask

  // One instruction: gap idle cycles, accept, stub schedule (pre silent cycles,
  // wlen wait cycles, then ready if claim, else silence), then hold cycles of
  // response backpressure. abort_at > 0 asserts rst in that issue cycle.
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int gap, input int pre, input int wlen, input bit claim,
                         input logic wr, input logic [31:0] rd, input int hold, input int abort_at);
    int len;
    bit ill;
    logic [4:0] idx;
    idx = insn[11:7];
    if (pre >= T) begin
      len = T; ill = 1'b1;
    end else if (claim) begin
      len = pre + wlen + 1; ill = 1'b0;
    end else if (wlen == 0) begin
      len = T; ill = 1'b1;
    end else begin
      len = pre + wlen + T; ill = 1'b1;
    end
    for (int g = 0; g < gap; g++) begin
      junk_inputs(); bus.req_valid_i = 1'b0;
      step(); set_idle();
    end
    junk_inputs();
    bus.req_valid_i = 1'b1; bus.req_insn_i = insn; bus.req_rs1_i = rs1; bus.req_rs2_i = rs2;
    step();
    bus.req_valid_i = 1'b0;
    set_issue(insn, rs1, rs2);
    for (int i = 1; i <= len; i++) begin
      junk_inputs();
      if (i <= pre) drive_stub(1'b0, 1'b0, 1'($urandom), $urandom);
      else if (i <= pre + wlen) drive_stub(1'b1, 1'b0, 1'($urandom), $urandom);
      else if (claim) drive_stub(1'($urandom), 1'b1, wr, rd);
      else drive_stub(1'b0, 1'b0, 1'($urandom), $urandom);
      if (i == abort_at) rst = 1'b1;
      step();
      if (i == abort_at) begin
        rst = 1'b0;
        set_reset();
        return;
      end
      if (i < len) set_issue(insn, rs1, rs2);
      else if (ill) set_resp(1'b0, idx, 32'd0, 1'b1);
      else set_resp(wr && (idx != 5'd0), idx, wr ? rd : 32'd0, 1'b0);
    end
    for (int h = 0; h <= hold; h++) begin
      junk_inputs();
      bus.req_valid_i = 1'($urandom);
      bus.rsp_ready_i = (h == hold);
      step();
      if (h < hold) set_resp(exp_wr, exp_idx, exp_rd, exp_ill);
      else set_idle();
    end
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    int nrsp_before;
    bus.req_valid_i = 1'b0; bus.req_insn_i = 32'd0; bus.req_rs1_i = 32'd0; bus.req_rs2_i = 32'd0;
    drive_stub(1'b0, 1'b0, 1'b0, 32'd0);
    bus.rsp_ready_i = 1'b0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    set_reset();
    step();
    rst = 1'b0;
    step();
    set_idle();

    // SLLI x1,x2,4: ready one cycle after valid
    run_txn(32'h0041_1093, 32'h0000_000F, 32'd0, 0, 1, 0, 1'b1, 1'b1, 32'h0000_00F0, 0, 0);
    cmp("slli_lat", 32'(last_lat), 32'd2);
    cmp("slli_wr", 32'(mon_wr), 32'd1);
    cmp("slli_idx", 32'(mon_idx), 32'd1);
    cmp("slli_rd", mon_rd, 32'h0000_00F0);
    cmp("slli_ill", 32'(mon_ill), 32'd0);

    // LW x1,64(x2): 40 wait cycles, no timeout
    run_txn(32'h0401_2083, 32'd0, 32'd0, 1, 0, 40, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 0);
    cmp("lw_lat", 32'(last_lat), 32'd41);
    cmp("lw_rd", mon_rd, 32'hDEAD_BEEF);
    cmp("lw_wr", 32'(mon_wr), 32'd1);
    cmp("lw_ill", 32'(mon_ill), 32'd0);

    // Unclaimed instruction times out
    run_txn(32'h0000_058B, 32'h1, 32'h2, 0, 0, 0, 1'b0, 1'b0, 32'd0, 0, 0);
    cmp("tmo_lat", 32'(last_lat), 32'd16);
    cmp("tmo_ill", 32'(mon_ill), 32'd1);
    cmp("tmo_wr", 32'(mon_wr), 32'd0);
    cmp("tmo_rd", mon_rd, 32'd0);

    // Ready on the last allowed cycle beats timeout
    run_txn(32'h0000_02B3, 32'h3, 32'h4, 0, 15, 0, 1'b1, 1'b1, 32'h0000_A5A5, 0, 0);
    cmp("edge_lat", 32'(last_lat), 32'd16);
    cmp("edge_ill", 32'(mon_ill), 32'd0);
    cmp("edge_rd", mon_rd, 32'h0000_A5A5);

    // SW x3,8(x2): rd field 8, stub wr=0
    run_txn(32'h0031_2423, 32'h100, 32'h55, 0, 0, 0, 1'b1, 1'b0, 32'h0000_0055, 0, 0);
    cmp("sw_wr", 32'(mon_wr), 32'd0);
    cmp("sw_rd", mon_rd, 32'd0);
    cmp("sw_ill", 32'(mon_ill), 32'd0);

    // ADD x0,x1,x2 with wr=1: register write suppressed
    run_txn(32'h0020_8033, 32'h7, 32'h9, 0, 0, 0, 1'b1, 1'b1, 32'h0000_1234, 0, 0);
    cmp("x0_wr", 32'(mon_wr), 32'd0);
    cmp("x0_idx", 32'(mon_idx), 32'd0);

    // Backpressure for 5 cycles, then a back-to-back request
    run_txn(32'h00A5_8533, 32'hA, 32'hB, 0, 2, 1, 1'b1, 1'b1, 32'hCAFE_0001, 5, 0);
    run_txn(32'h00C6_8633, 32'hC, 32'hD, 0, 0, 0, 1'b1, 1'b1, 32'hCAFE_0002, 0, 0);

    // Reset on the 3rd issue cycle drops the instruction
    nrsp_before = nrsp;
    run_txn(32'h00E7_0733, 32'hE, 32'hF, 0, 10, 0, 1'b1, 1'b1, 32'h1111_1111, 0, 3);
    step(); set_idle();
    cmp("abort_no_rsp", 32'(nrsp), 32'(nrsp_before));
    run_txn(32'h0041_1093, 32'h5, 32'h6, 0, 0, 0, 1'b1, 1'b1, 32'h2222_2222, 1, 0);
    cmp("after_abort_rd", mon_rd, 32'h2222_2222);

    for (int n = 0; n < 40; n++) begin
      run_txn($urandom, $urandom, $urandom, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 6)),
              1'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)), 0);
    end

    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
